// File: rtl/clock_pkg.sv
// clock_pkg: field selectors, field limits and calendar helpers shared by the timekeeping datapath.
package clock_pkg;

    localparam logic [2:0] SEL_SEC   = 3'd0;
    localparam logic [2:0] SEL_MIN   = 3'd1;
    localparam logic [2:0] SEL_HOUR  = 3'd2;
    localparam logic [2:0] SEL_DAY   = 3'd3;
    localparam logic [2:0] SEL_MONTH = 3'd4;
    localparam logic [2:0] SEL_YEAR  = 3'd5;

    localparam int SEC_MAX   = 59;
    localparam int MIN_MAX   = 59;
    localparam int HOUR_MAX  = 23;
    localparam int MONTH_MAX = 12;
    localparam int YEAR_MAX  = 9999;

    function automatic logic is_leap(input logic [13:0] y);
        return (y[1:0] == 2'd0) && (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
    endfunction

    // One edit step inside [lo, hi], wrapping at both ends.
    function automatic logic [13:0] wrap_step(input logic [13:0] v, input logic [13:0] lo,
                                              input logic [13:0] hi, input logic inc);
        return inc ? ((v >= hi) ? lo : v + 14'd1) : ((v <= lo) ? hi : v - 14'd1);
    endfunction

endpackage

// File: rtl/days_in_month.sv
// days_in_month: number of days in a month for a given year, leap-year aware.
module days_in_month
    import clock_pkg::*;
(
    input  logic [3:0]  month,
    input  logic [13:0] year,
    output logic [4:0]  dim
);

    always_comb begin
        dim = (month == 4'd2) ? (is_leap(year) ? 5'd29 : 5'd28) :
              (month == 4'd4 || month == 4'd6 || month == 4'd9 || month == 4'd11) ? 5'd30 : 5'd31;
    end

endmodule

// File: rtl/time_date_counter.sv
// time_date_counter: 1 Hz calendar counter with per-field up/down editing.
module time_date_counter
    import clock_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int YEAR_RESET  = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_1,
    input  logic        dem_chinh,
    input  logic [2:0]  select_item,
    input  logic        up,
    input  logic        down,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [4:0]  hour,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [13:0] year,
    output logic        tick_1hz
);

    localparam int PW = $clog2(CLK_FREQ_HZ + 1);
    localparam logic [PW-1:0] PSC_MAX = PW'(CLK_FREQ_HZ - 1);

    logic [PW-1:0] psc;
    logic          counting, tick, edit;
    logic          c_s, c_m, c_h, c_d, c_mo;
    logic [4:0]    dim_cur, dim_new;
    logic [5:0]    sec_t, min_t, sec_e, min_e;
    logic [4:0]    hour_t, day_t, hour_e, day_e;
    logic [3:0]    month_t, month_e;
    logic [13:0]   year_t, year_e;

    days_in_month u_dim_cur (.month(month),   .year(year),   .dim(dim_cur));
    days_in_month u_dim_new (.month(month_e), .year(year_e), .dim(dim_new));

    always_comb begin
        counting = en_1 && !dem_chinh;
        tick     = counting && (psc == PSC_MAX);
        edit     = dem_chinh && (up ^ down);
        c_s      = sec == 6'(SEC_MAX);
        c_m      = c_s && (min == 6'(MIN_MAX));
        c_h      = c_m && (hour == 5'(HOUR_MAX));
        c_d      = c_h && (day >= dim_cur);
        c_mo     = c_d && (month == 4'(MONTH_MAX));
        sec_t    = c_s ? 6'd0 : sec + 6'd1;
        min_t    = !c_s ? min : (c_m ? 6'd0 : min + 6'd1);
        hour_t   = !c_m ? hour : (c_h ? 5'd0 : hour + 5'd1);
        day_t    = !c_h ? day : (c_d ? 5'd1 : day + 5'd1);
        month_t  = !c_d ? month : (c_mo ? 4'd1 : month + 4'd1);
        year_t   = !c_mo ? year : ((year == 14'(YEAR_MAX)) ? 14'd0 : year + 14'd1);
        sec_e    = (edit && select_item == SEL_SEC)
                 ? 6'(wrap_step(14'(sec), 14'd0, 14'(SEC_MAX), up)) : sec;
        min_e    = (edit && select_item == SEL_MIN)
                 ? 6'(wrap_step(14'(min), 14'd0, 14'(MIN_MAX), up)) : min;
        hour_e   = (edit && select_item == SEL_HOUR)
                 ? 5'(wrap_step(14'(hour), 14'd0, 14'(HOUR_MAX), up)) : hour;
        month_e  = (edit && select_item == SEL_MONTH)
                 ? 4'(wrap_step(14'(month), 14'd1, 14'(MONTH_MAX), up)) : month;
        year_e   = (edit && select_item == SEL_YEAR)
                 ? wrap_step(year, 14'd0, 14'(YEAR_MAX), up) : year;
        // Outside a day edit the day is clamped to the (possibly new) month length.
        day_e    = (edit && select_item == SEL_DAY)
                 ? 5'(wrap_step(14'(day), 14'd1, 14'(dim_cur), up))
                 : ((day > dim_new) ? dim_new : day);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc      <= '0;
            tick_1hz <= 1'b0;
            sec      <= 6'd0;
            min      <= 6'd0;
            hour     <= 5'd0;
            day      <= 5'd1;
            month    <= 4'd1;
            year     <= 14'(YEAR_RESET);
        end else begin
            psc      <= (counting && !tick) ? psc + 1'b1 : '0;
            tick_1hz <= tick;
            sec      <= tick ? sec_t   : sec_e;
            min      <= tick ? min_t   : min_e;
            hour     <= tick ? hour_t  : hour_e;
            day      <= tick ? day_t   : day_e;
            month    <= tick ? month_t : month_e;
            year     <= tick ? year_t  : year_e;
        end
    end

endmodule

// File: tb/tb_time_date_counter.sv
// tb_time_date_counter: directed checks of counting, rollover, leap years, editing and clamping.
module tb_time_date_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_1 = 1'b0;
    logic        dem_chinh = 1'b0;
    logic [2:0]  select_item = 3'd0;
    logic        up = 1'b0;
    logic        down = 1'b0;
    logic [5:0]  sec, min;
    logic [4:0]  hour, day;
    logic [3:0]  month;
    logic [13:0] year;
    logic        tick_1hz;
    int          checks = 0;
    int          errors = 0;

    time_date_counter #(.CLK_FREQ_HZ(4), .YEAR_RESET(2000)) dut (
        .clk(clk), .rst(rst), .en_1(en_1), .dem_chinh(dem_chinh), .select_item(select_item),
        .up(up), .down(down), .sec(sec), .min(min), .hour(hour), .day(day), .month(month),
        .year(year), .tick_1hz(tick_1hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int s, input int mi, input int h,
                             input int d, input int mo, input int y);
        check({tag, ".sec"}, int'(sec), s);
        check({tag, ".min"}, int'(min), mi);
        check({tag, ".hour"}, int'(hour), h);
        check({tag, ".day"}, int'(day), d);
        check({tag, ".month"}, int'(month), mo);
        check({tag, ".year"}, int'(year), y);
    endtask

    function automatic int get(input logic [2:0] s);
        return (s == 3'd0) ? int'(sec) : (s == 3'd1) ? int'(min) : (s == 3'd2) ? int'(hour) :
               (s == 3'd3) ? int'(day) : (s == 3'd4) ? int'(month) : int'(year);
    endfunction

    task automatic edit_pulse(input logic [2:0] s, input logic dm, input logic u, input logic d);
        @(negedge clk);
        select_item = s;
        dem_chinh = dm;
        up = u;
        down = d;
        @(negedge clk);
        up = 1'b0;
        down = 1'b0;
    endtask

    task automatic step_to(input logic [2:0] s, input int target);
        for (int i = 0; i < 10000 && get(s) != target; i++)
            edit_pulse(s, 1'b1, get(s) < target, get(s) > target);
        check("preload", get(s), target);
    endtask

    task automatic preload(input int s, input int mi, input int h, input int d,
                           input int mo, input int y);
        step_to(3'd4, mo);
        step_to(3'd5, y);
        step_to(3'd3, d);
        step_to(3'd2, h);
        step_to(3'd1, mi);
        step_to(3'd0, s);
    endtask

    // Leaves edit mode and waits for one tick; a fresh prescaler must tick after 4 clocks.
    task automatic wait_tick(input string tag);
        int n = 0;
        @(negedge clk);
        dem_chinh = 1'b0;
        en_1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (tick_1hz) break;
        end
        en_1 = 1'b0;
        check({tag, ".latency"}, n, 4);
    endtask

    initial begin
        int ticks;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all("reset", 0, 0, 0, 1, 1, 2000);
        check("reset.tick", int'(tick_1hz), 0);
        wait_tick("first");
        check("first.sec", int'(sec), 1);
        @(negedge clk);
        check("first.tick_len", int'(tick_1hz), 0);

        preload(59, 59, 23, 31, 12, 2099);
        wait_tick("newyear");
        check_all("newyear", 0, 0, 0, 1, 1, 2100);
        preload(59, 59, 23, 31, 12, 9999);
        wait_tick("y9999");
        check_all("y9999", 0, 0, 0, 1, 1, 0);

        preload(59, 59, 23, 28, 2, 2024);
        wait_tick("leap2024");
        check_all("leap2024", 0, 0, 0, 29, 2, 2024);
        preload(59, 59, 23, 28, 2, 2100);
        wait_tick("noleap2100");
        check_all("noleap2100", 0, 0, 0, 1, 3, 2100);
        preload(59, 59, 23, 28, 2, 2000);
        wait_tick("leap2000");
        check_all("leap2000", 0, 0, 0, 29, 2, 2000);

        edit_pulse(3'd0, 1'b1, 1'b0, 1'b1);
        check_all("sec_down", 59, 0, 0, 29, 2, 2000);
        step_to(3'd2, 23);
        edit_pulse(3'd2, 1'b1, 1'b1, 1'b0);
        check_all("hour_up", 59, 0, 0, 29, 2, 2000);
        step_to(3'd3, 1);
        edit_pulse(3'd3, 1'b1, 1'b0, 1'b1);
        check_all("day_down", 59, 0, 0, 29, 2, 2000);

        step_to(3'd4, 1);
        step_to(3'd5, 2023);
        step_to(3'd3, 31);
        edit_pulse(3'd4, 1'b1, 1'b1, 1'b0);
        check_all("clamp_month", 59, 0, 0, 28, 2, 2023);
        step_to(3'd5, 2024);
        step_to(3'd3, 29);
        edit_pulse(3'd5, 1'b1, 1'b1, 1'b0);
        check_all("clamp_year", 59, 0, 0, 28, 2, 2025);

        edit_pulse(3'd0, 1'b1, 1'b1, 1'b1);
        check_all("up_and_down", 59, 0, 0, 28, 2, 2025);
        edit_pulse(3'd6, 1'b1, 1'b1, 1'b0);
        edit_pulse(3'd7, 1'b1, 1'b0, 1'b1);
        check_all("bad_sel", 59, 0, 0, 28, 2, 2025);
        edit_pulse(3'd0, 1'b0, 1'b1, 1'b0);
        check_all("up_no_edit", 59, 0, 0, 28, 2, 2025);

        ticks = 0;
        en_1 = 1'b0;
        repeat (20) begin
            @(negedge clk);
            ticks += int'(tick_1hz);
        end
        check("en_low.ticks", ticks, 0);
        dem_chinh = 1'b1;
        en_1 = 1'b1;
        repeat (10) begin
            @(negedge clk);
            ticks += int'(tick_1hz);
        end
        check("edit_override.ticks", ticks, 0);
        wait_tick("resume");
        check_all("resume", 0, 1, 0, 28, 2, 2025);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
